// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Measures an incoming PWM waveform. It reports the high time and the
//   rise-to-rise period of the last complete cycle. It also reports a duty
//   code on the same scale as the generator's duty input:
//   duty = floor(high * 2^DUTY_W / period).
//   If no rising edge arrives for TIMEOUT cycles, the input is flagged as
//   static.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   pwm_in     in   1       PWM input, asynchronous to clk
//   high_time  out  CNT_W   high cycles in last complete period
//   period     out  CNT_W   rise-to-rise distance in cycles
//   duty_out   out  DUTY_W  normalised duty of last period
//   valid      out  1       one-cycle pulse: results just updated
//   stuck      out  1       no rising edge for TIMEOUT cycles
// ---------------------------------------------------------------------------
module pwm_capture #(
   parameter int CNT_W   = 16,
   parameter int DUTY_W  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  high_time,
   output logic [CNT_W-1:0]  period,
   output logic [DUTY_W-1:0] duty_out,
   output logic              valid,
   output logic              stuck
);

   localparam int BW = (DUTY_W > 2) ? $clog2(DUTY_W) : 1;
   localparam logic [CNT_W-1:0]  LP_CNT_MAX  = '1;
   localparam logic [DUTY_W-1:0] LP_DUTY_MAX = '1;
   // cp value in the last cycle before the timeout fires (cp+1 == TIMEOUT)
   localparam logic [CNT_W-1:0]  LP_TO_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_t;

   state_t             r_state, w_state_next;
   logic               r_s0, r_s1, r_s2;
   logic [CNT_W-1:0]   r_cp, r_ch;
   logic               r_armed;
   logic [CNT_W-1:0]   r_h, r_p, r_rem;
   logic               r_sat;
   logic [DUTY_W-2:0]  r_quo;
   logic [BW-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]   r_high_time, r_period;
   logic [DUTY_W-1:0]  r_duty;
   logic               r_valid, r_stuck;

   logic               w_rise, w_capture, w_timeout, w_last_step;
   logic [CNT_W:0]     w_rem_shift;
   logic               w_ge;
   logic [CNT_W-1:0]   w_rem_next;
   logic [DUTY_W-1:0]  w_quo_next;

   assign w_rise    = r_s1 & ~r_s2;
   assign w_capture = w_rise & r_armed;
   assign w_timeout = r_armed & ~w_rise & (r_cp == LP_TO_LAST);

   // The result only goes out if nothing restarts or cancels the division
   // on its final step.
   assign w_last_step = (r_state == ST_DIV) && (r_bit_cnt == '0) && !w_capture && !w_timeout;

   // The dividend is H * 2^DUTY_W. When H < P the quotient fits in DUTY_W
   // bits, so the upper dividend bits seed the remainder directly. The
   // DUTY_W low (zero) bits are then shifted in one per cycle, MSB first.
   // The remainder always stays below P. That keeps the subtraction
   // within CNT_W bits.
   assign w_rem_shift = {r_rem, 1'b0};
   assign w_ge        = (w_rem_shift >= {1'b0, r_p});
   assign w_rem_next  = w_ge ? (w_rem_shift[CNT_W-1:0] - r_p) : w_rem_shift[CNT_W-1:0];
   assign w_quo_next  = {r_quo, w_ge};

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // FSM next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: w_state_next = ST_IDLE;
         ST_DIV:  if (r_bit_cnt == '0) w_state_next = ST_DONE;
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
      // A new capture always restarts the division (latest wins).
      if (w_capture) w_state_next = ST_DIV;
      // A timeout abandons any division in flight.
      if (w_timeout) w_state_next = ST_IDLE;
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0        <= 1'b0;
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_cp        <= '0;
         r_ch        <= '0;
         r_armed     <= 1'b0;
         r_h         <= '0;
         r_p         <= '0;
         r_rem       <= '0;
         r_sat       <= 1'b0;
         r_quo       <= '0;
         r_bit_cnt   <= '0;
         r_high_time <= '0;
         r_period    <= '0;
         r_duty      <= '0;
         r_valid     <= 1'b0;
         r_stuck     <= 1'b0;
      end else begin
         r_s0 <= pwm_in;
         r_s1 <= r_s0;
         r_s2 <= r_s1;

         // Period and high-time counters. Both saturate.
         if (w_rise) begin
            r_cp <= CNT_W'(1);
            r_ch <= CNT_W'(1);
         end else begin
            if (r_cp != LP_CNT_MAX)          r_cp <= r_cp + CNT_W'(1);
            if (r_s1 && r_ch != LP_CNT_MAX)  r_ch <= r_ch + CNT_W'(1);
         end

         if (w_rise)         r_armed <= 1'b1;
         else if (w_timeout) r_armed <= 1'b0;

         if (w_capture) begin
            r_h       <= r_ch;
            r_p       <= r_cp;
            r_sat     <= (r_ch >= r_cp);
            r_rem     <= r_ch;
            r_quo     <= '0;
            r_bit_cnt <= BW'(DUTY_W - 1);
         end else if (r_state == ST_DIV) begin
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next[DUTY_W-2:0];
            r_bit_cnt <= r_bit_cnt - BW'(1);
         end

         // Result registers are loaded on the final divide step.
         // They become visible together with valid, in the DONE cycle.
         r_valid <= 1'b0;
         if (w_timeout) begin
            r_high_time <= '0;
            r_period    <= '0;
            r_duty      <= r_s1 ? LP_DUTY_MAX : '0;
            r_valid     <= 1'b1;
            r_stuck     <= 1'b1;
         end else if (w_last_step) begin
            r_high_time <= r_h;
            r_period    <= r_p;
            r_duty      <= r_sat ? LP_DUTY_MAX : w_quo_next;
            r_valid     <= 1'b1;
         end

         if (w_rise) r_stuck <= 1'b0;
      end
   end

   assign high_time = r_high_time;
   assign period    = r_period;
   assign duty_out  = r_duty;
   assign valid     = r_valid;
   assign stuck     = r_stuck;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//   Drives PWM patterns, both directed and random. The reference model works
//   from rise times and high-cycle counts. It schedules the expected result
//   DUTY_W+1 cycles after each armed rise, and each new capture replaces the
//   pending result. It also predicts the timeout event TIMEOUT cycles after
//   the last rise. All outputs are compared every cycle. Literal
//   expectations pin the model's arithmetic.
// ---------------------------------------------------------------------------
module tb_pwm_capture;
   localparam int CNT_W   = 16;
   localparam int DUTY_W  = 8;
   localparam int TIMEOUT = 1024;
   localparam int DMAX    = (1 << DUTY_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pwm_in = 1'b0;
   logic [CNT_W-1:0]  high_time, period;
   logic [DUTY_W-1:0] duty_out;
   logic              valid, stuck;

   pwm_capture #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in),
      .high_time(high_time), .period(period), .duty_out(duty_out),
      .valid(valid), .stuck(stuck)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   int cyc = 0;
   bit h0, h1, h2;                     // pwm level as seen by the DUT, by cycle age
   bit m_armed;
   int m_last_rise, m_highs;
   bit pend;
   int pend_due, pend_h, pend_p, pend_d;
   bit exp_valid, exp_stuck;
   int exp_ht, exp_p, exp_d;
   // DUT values recorded at each valid pulse, for the literal checks
   int n_valid = 0, last_valid_cyc = 0, prev_valid_cyc = 0;
   int rec_ht = 0, rec_p = 0, rec_d = 0;

   always @(posedge clk) begin
      bit rise, nv;
      #1;
      cyc++;
      if (rst) begin
         h0 = 0; h1 = 0; h2 = 0;
         m_armed = 0; pend = 0;
         exp_valid = 0; exp_stuck = 0; exp_ht = 0; exp_p = 0; exp_d = 0;
         chk("rst_outputs", {high_time, period}, 32'd0);
         chk("rst_flags", {duty_out, valid, stuck}, 32'd0);
      end else begin
         h2 = h1; h1 = h0; h0 = pwm_in;
         chk("valid", valid, exp_valid);
         chk("stuck", stuck, exp_stuck);
         chk("high_time", high_time, exp_ht);
         chk("period", period, exp_p);
         chk("duty_out", duty_out, exp_d);
         if (valid) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            rec_ht = high_time; rec_p = period; rec_d = duty_out;
         end
         // decide what the DUT must show next cycle
         rise = h1 && !h2;
         nv = 0;
         if (rise) begin
            if (m_armed) begin
               pend     = 1;
               pend_due = cyc + DUTY_W + 1;
               pend_p   = cyc - m_last_rise;
               pend_h   = m_highs;
               pend_d   = (pend_h >= pend_p) ? DMAX : (pend_h << DUTY_W) / pend_p;
            end
            m_armed = 1; exp_stuck = 0; m_last_rise = cyc; m_highs = 1;
         end else begin
            m_highs += int'(h1);
            if (m_armed && (cyc - m_last_rise) + 1 == TIMEOUT) begin
               m_armed = 0; pend = 0; exp_stuck = 1;
               exp_ht = 0; exp_p = 0; exp_d = h1 ? DMAX : 0;
               nv = 1;
            end
         end
         if (!nv && pend && pend_due == cyc + 1) begin
            exp_ht = pend_h; exp_p = pend_p; exp_d = pend_d;
            nv = 1; pend = 0;
         end
         exp_valid = nv;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input int n);
      repeat (n) begin
         @(negedge clk);
         pwm_in = v;
      end
   endtask

   task automatic pulse(input int h, input int p);
      drive(1'b1, h);
      drive(1'b0, p - h);
   endtask

   initial begin
      int n0, p, h;
      repeat (3) @(negedge clk);
      chk("reset_state", {high_time, period, duty_out, valid, stuck}, 32'd0);
      rst = 1'b0;

      // T1: duty 25 of 256; the first rise only arms
      n0 = n_valid;
      repeat (5) pulse(25, 256);
      chk("t1_count", n_valid - n0, 4);
      chk("t1_high", rec_ht, 25);
      chk("t1_period", rec_p, 256);
      chk("t1_duty", rec_d, 25);

      // T2: duty step 50 -> 200
      repeat (3) pulse(50, 256);
      repeat (3) pulse(200, 256);
      chk("t2_high", rec_ht, 200);
      chk("t2_duty", rec_d, 200);
      chk("t2_spacing", last_valid_cyc - prev_valid_cyc, 256);

      // T3: half duty at period 100, then very short periods
      repeat (3) pulse(50, 100);
      chk("t3_duty_half", rec_d, 128);
      chk("t3_period", rec_p, 100);
      repeat (3) pulse(2, 3);
      drive(1'b0, 20);
      chk("t3_short_duty", rec_d, 170);
      chk("t3_short_period", rec_p, 3);

      // T4: static low, static high, then resume
      drive(1'b0, TIMEOUT + 20);
      chk("t4_stuck_low", stuck, 1);
      chk("t4_low_duty", rec_d, 0);
      chk("t4_low_period", rec_p, 0);
      repeat (3) pulse(30, 100);
      drive(1'b1, TIMEOUT + 20);
      chk("t4_stuck_high", stuck, 1);
      chk("t4_high_duty", rec_d, DMAX);
      drive(1'b0, 10);
      n0 = n_valid;
      drive(1'b1, 30);
      chk("t4_stuck_clear", stuck, 0);
      chk("t4_no_valid_first_rise", n_valid - n0, 0);
      drive(1'b0, 70);
      pulse(30, 100);
      chk("t4_resume_count", n_valid - n0, 1);
      chk("t4_resume_period", rec_p, 100);
      chk("t4_resume_duty", rec_d, 76);

      // T5: reset in the middle of a division
      repeat (2) pulse(40, 256);
      drive(1'b1, 5);
      @(negedge clk);
      rst = 1'b1; pwm_in = 1'b0;
      #1;
      chk("t5_async_zero", {high_time, period, duty_out, valid, stuck}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n0 = n_valid;
      drive(1'b0, 10);
      pulse(40, 256);
      chk("t5_first_rise_silent", n_valid - n0, 0);
      pulse(40, 256);
      chk("t5_capture_count", n_valid - n0, 1);
      chk("t5_capture_duty", rec_d, 40);
      chk("t5_capture_period", rec_p, 256);

      // T6: rises closer together than the divide latency
      n0 = n_valid;
      repeat (10) pulse(2, 5);
      drive(1'b0, 20);
      chk("t6_count", n_valid - n0, 1);
      chk("t6_period", rec_p, 5);
      chk("t6_duty", rec_d, 102);

      // Random periods and duties
      repeat (40) begin
         p = $urandom_range(300, 2);
         h = $urandom_range(p - 1, 1);
         pulse(h, p);
      end
      drive(1'b0, 30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
